bbs_stream: RTL and testbench

Parametrised Blum-Blum-Shub generator: successor to the single-bit, combinational-squaring generator. Validates each seed in-block with an iterative GCD, then squares the state modulo `M` with a bit-serial modular multiplier. Emits `B` low-order state bits per squaring over a valid/ready stream. Sits between the seed source and the downstream bit consumer.

---
 rtl/bbs_pkg.sv | 28 ++
 rtl/bbs_modmul.sv | 67 ++++++
 rtl/bbs_stream.sv | 142 ++++++++++++++
 tb/tb_bbs_stream.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bbs_pkg.sv
// Shared types and helpers for the Blum-Blum-Shub stream generator.
package bbs_pkg;

    // Top-level controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SQ    = 2'd2,
        ST_OUT   = 2'd3
    } bbs_state_e;

    // Width of the default 16-bit configuration's modular accumulator.
    localparam int BBS_ACC_W_DEFAULT = 17;

    // The accumulator holds values below 2*M, so it needs one bit beyond the state width.
    function automatic int acc_width(input int w);
        return w + 1;
    endfunction

    // Legal configuration: M odd, 3 <= M < 2^W, 1 <= B <= W.
    function automatic bit params_ok(input int w, input int m, input int b);
        longint lim;
        lim = longint'(1) << w;
        return (w >= 2) && (w <= 31) && (m >= 3) && ((m % 2) == 1) &&
               (longint'(m) < lim) && (b >= 1) && (b <= w);
    endfunction

endpackage

// File: rtl/bbs_modmul.sv
// Bit-serial modular squarer: result = x*x mod M, MSB-first interleaved, W cycles.
// done_o is high during the last working cycle and result_o is valid then,
// so the caller can capture the result on the same edge that finishes the job.
module bbs_modmul
    import bbs_pkg::*;
#(
    parameter int W = 16,
    parameter int M = 253
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] x_i,
    output logic         done_o,
    output logic [W-1:0] result_o
);

    localparam int AW = acc_width(W);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [AW-1:0] M_A = AW'(M);

    logic [AW-1:0] acc_q;
    logic [W-1:0]  op_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    logic [AW-1:0] dbl;
    logic [AW-1:0] dbl_red;
    logic [AW-1:0] add;
    logic [AW-1:0] add_red;
    logic [AW-1:0] acc_d;

    // One interleaved step: double and reduce, then conditionally add x and reduce.
    always_comb begin
        dbl     = acc_q << 1;
        dbl_red = (dbl >= M_A) ? (dbl - M_A) : dbl;
        add     = dbl_red + {1'b0, op_q};
        add_red = (add >= M_A) ? (add - M_A) : add;
        acc_d   = op_q[cnt_q] ? add_red : dbl_red;
    end

    assign done_o   = busy_q && (cnt_q == '0);
    assign result_o = acc_d[W-1:0];

    // Operand latch, accumulator and bit counter walking from bit W-1 down to bit 0.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            acc_q  <= '0;
            op_q   <= x_i;
            cnt_q  <= CW'(W - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bbs_stream.sv
// Blum-Blum-Shub stream generator: validates seeds with a subtractive GCD against M,
// then repeatedly squares the state modulo M and streams its low B bits.
module bbs_stream
    import bbs_pkg::*;
#(
    parameter int W = 16,
    parameter int M = 253,
    parameter int B = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] seed_in,
    input  logic         seed_valid,
    output logic         seed_ready,
    output logic         seed_err,
    output logic [B-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic [W-1:0] x_out
);

    localparam logic [W-1:0] M_W = W'(M);

    if (!params_ok(W, M, B)) begin : g_param_err
        $error("bbs_stream: illegal W/M/B combination");
    end

    bbs_state_e   state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         seed_err_q, seed_err_d;

    logic         mul_start;
    logic         mul_done;
    logic [W-1:0] mul_result;
    logic         seed_ok;

    assign seed_ok = (seed_in >= W'(2)) && (seed_in < M_W);

    bbs_modmul #(
        .W (W),
        .M (M)
    ) u_modmul (
        .clk      (clk),
        .rst_ni   (reset),
        .start_i  (mul_start),
        .x_i      (x_q),
        .done_o   (mul_done),
        .result_o (mul_result)
    );

    // Next-state logic: seed intake, Euclid steps, squaring hand-off and stream handshake.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        a_d        = a_q;
        b_d        = b_q;
        seed_err_d = 1'b0;
        mul_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seed_valid) begin
                    if (seed_ok) begin
                        x_d     = seed_in;
                        a_d     = seed_in;
                        b_d     = M_W;
                        state_d = ST_CHECK;
                    end else begin
                        seed_err_d = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (a_q == b_q) begin
                    if (a_q == W'(1)) begin
                        state_d   = ST_SQ;
                        mul_start = 1'b1;
                    end else begin
                        seed_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            ST_SQ: begin
                if (mul_done) begin
                    x_d     = mul_result;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                // A new seed always wins over squaring; the current word still
                // transfers if the consumer happens to be ready on the same edge.
                if (seed_valid) begin
                    if (seed_ok) begin
                        x_d     = seed_in;
                        a_d     = seed_in;
                        b_d     = M_W;
                        state_d = ST_CHECK;
                    end else begin
                        seed_err_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end else if (out_ready) begin
                    state_d   = ST_SQ;
                    mul_start = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, working registers and the registered reject pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            a_q        <= a_d;
            b_q        <= b_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign seed_ready = (state_q == ST_IDLE) || (state_q == ST_OUT);
    assign seed_err   = seed_err_q;
    assign out_valid  = (state_q == ST_OUT);
    assign out_data   = x_q[B-1:0];
    assign busy       = (state_q == ST_CHECK) || (state_q == ST_SQ);
    assign x_out      = x_q;

endmodule

// File: tb/tb_bbs_stream.sv
// Scoreboard bench for bbs_stream (W=16, M=253, B=2).
module tb_bbs_stream;

    localparam int W = 16;
    localparam int M = 253;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] seed_in;
    logic         seed_valid;
    logic         seed_ready;
    logic         seed_err;
    logic [B-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic [W-1:0] x_out;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    bbs_stream #(.W(W), .M(M), .B(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .seed_in    (seed_in),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_err   (seed_err),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .x_out      (x_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int euclid_cycles(input int s);
        int a, b, n;
        a = s; b = M; n = 0;
        for (int k = 0; k < 2000; k++) begin
            n++;
            if (a == b) break;
            if (a > b) a = a - b;
            else b = b - a;
        end
        return n;
    endfunction

    function automatic int sq_mod(input int x);
        return int'((longint'(x) * longint'(x)) % M);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int seed, input int n);
        int x;
        x = seed;
        for (int k = 0; k < n; k++) begin
            x = sq_mod(x);
            exp_q.push_back(W'(x));
        end
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        seed_in    = '0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic offer_seed(input logic [W-1:0] s);
        int k;
        seed_in    = s;
        seed_valid = 1'b1;
        k = 0;
        while (!seed_ready && k < 500) begin
            tick();
            k++;
        end
        n_cmp++;
        if (!seed_ready) begin
            n_bad++;
            $display("FAIL seed_accept: seed_ready got %0b expected 1 (seed %0d)", seed_ready, s);
        end
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        seed_in    = '0;
        tick();
        tick();
        n_cmp += 6;
        if (seed_ready !== 1'b1) begin n_bad++; $display("FAIL reset_seed_ready: got %0b expected 1", seed_ready); end
        if (seed_err !== 1'b0) begin n_bad++; $display("FAIL reset_seed_err: got %0b expected 0", seed_err); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        if (x_out !== '0) begin n_bad++; $display("FAIL reset_x_out: got %0d expected 0", x_out); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_stream(input int seed, input int nwords);
        int en, busy_cnt, got, cyc, last;
        logic [W-1:0] e;
        exp_q.delete();
        out_ready = 1'b1;
        push_words(seed, nwords);
        en = euclid_cycles(seed);
        offer_seed(W'(seed));
        busy_cnt = 0; got = 0; cyc = 0; last = 0;
        while (got < nwords && cyc < 3000) begin
            if (busy) busy_cnt++;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (got == 0) begin
                    if (busy_cnt != en + W) begin
                        n_bad++;
                        $display("FAIL stream_latency: busy cycles got %0d expected %0d (seed %0d)", busy_cnt, en + W, seed);
                    end
                end else if (cyc - last != W + 1) begin
                    n_bad++;
                    $display("FAIL stream_spacing: got %0d expected %0d (seed %0d word %0d)", cyc - last, W + 1, seed, got);
                end
                last = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got word x=%0d expected none", x_out);
                end else begin
                    e = exp_q.pop_front();
                    if (x_out !== e || out_data !== e[B-1:0]) begin
                        n_bad++;
                        $display("FAIL stream_word: got x=%0d data=%0d expected x=%0d data=%0d (seed %0d)", x_out, out_data, e, e[B-1:0], seed);
                    end else begin
                        $display("stream seed %0d word %0d: x=%0d data=%0d", seed, got, x_out, out_data);
                    end
                end
                got++;
            end
            if (got < nwords) tick();
            cyc++;
        end
        n_cmp++;
        if (got != nwords) begin
            n_bad++;
            $display("FAIL stream_timeout: words got %0d expected %0d (seed %0d)", got, nwords, seed);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_bad_seeds();
        int bad[5] = '{11, 23, 0, 1, 253};
        int err_cnt, first_err, exp_first, cyc;
        bit saw_valid, done;
        do_reset();
        out_ready = 1'b1;
        foreach (bad[i]) begin
            exp_first = (bad[i] < 2 || bad[i] >= M) ? 0 : euclid_cycles(bad[i]);
            offer_seed(W'(bad[i]));
            err_cnt = 0; first_err = -1; saw_valid = 0; done = 0; cyc = 0;
            while (!done && cyc < 1000) begin
                if (out_valid) saw_valid = 1;
                if (seed_err) begin
                    if (err_cnt == 0) first_err = cyc;
                    err_cnt++;
                end
                if (err_cnt > 0 && !seed_err && !busy && seed_ready) done = 1;
                else begin
                    tick();
                    cyc++;
                end
            end
            n_cmp += 4;
            if (err_cnt != 1) begin n_bad++; $display("FAIL bad_seed_err_pulse: got %0d cycles expected 1 (seed %0d)", err_cnt, bad[i]); end
            if (first_err != exp_first) begin n_bad++; $display("FAIL bad_seed_err_time: got %0d expected %0d (seed %0d)", first_err, exp_first, bad[i]); end
            if (saw_valid) begin n_bad++; $display("FAIL bad_seed_out_valid: got 1 expected 0 (seed %0d)", bad[i]); end
            if (!done) begin n_bad++; $display("FAIL bad_seed_idle: got not-idle expected idle (seed %0d)", bad[i]); end
            else $display("bad seed %0d: seed_err at cycle %0d, back to idle", bad[i], first_err);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        int cyc;
        logic [W-1:0] e;
        do_reset();
        out_ready = 1'b0;
        push_words(3, 2);
        offer_seed(W'(3));
        cyc = 0;
        while (!out_valid && cyc < 500) begin tick(); cyc++; end
        n_cmp++;
        if (!out_valid) begin n_bad++; $display("FAIL hold_first_valid: got 0 expected 1"); end
        e = exp_q[0];
        for (int k = 0; k < 50; k++) begin
            n_cmp += 3;
            if (out_valid !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL hold_state: valid=%0b busy=%0b expected valid=1 busy=0 (cycle %0d)", out_valid, busy, k); end
            if (x_out !== e) begin n_bad++; $display("FAIL hold_x_out: got %0d expected %0d (cycle %0d)", x_out, e, k); end
            if (out_data !== e[B-1:0]) begin n_bad++; $display("FAIL hold_out_data: got %0d expected %0d (cycle %0d)", out_data, e[B-1:0], k); end
            tick();
        end
        out_ready = 1'b1;
        e = exp_q.pop_front();
        n_cmp++;
        if (x_out !== e) begin n_bad++; $display("FAIL hold_release_word: got %0d expected %0d", x_out, e); end
        else $display("hold released: x=%0d data=%0d", x_out, out_data);
        cyc = 0;
        tick(); cyc++;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
        e = exp_q.pop_front();
        n_cmp += 2;
        if (cyc != W + 1) begin n_bad++; $display("FAIL hold_next_latency: got %0d expected %0d", cyc, W + 1); end
        if (x_out !== e) begin n_bad++; $display("FAIL hold_next_word: got %0d expected %0d", x_out, e); end
        else $display("hold next word: x=%0d data=%0d", x_out, out_data);
        out_ready = 1'b0;
    endtask

    task automatic test_seed_during_out();
        int cyc, got, busy_cnt, en;
        logic [W-1:0] e;
        do_reset();
        out_ready = 1'b0;
        push_words(3, 1);
        offer_seed(W'(3));
        cyc = 0;
        while (!out_valid && cyc < 500) begin tick(); cyc++; end
        seed_in    = W'(5);
        seed_valid = 1'b1;
        out_ready  = 1'b1;
        e = exp_q.pop_front();
        n_cmp += 2;
        if (!(out_valid && seed_ready)) begin n_bad++; $display("FAIL both_handshake: valid=%0b ready=%0b expected 1 1", out_valid, seed_ready); end
        if (x_out !== e) begin n_bad++; $display("FAIL both_word: got %0d expected %0d", x_out, e); end
        else $display("both: transferred x=%0d, seed 5 taken", x_out);
        push_words(5, 2);
        en = euclid_cycles(5);
        tick();
        seed_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL both_check_state: busy=%0b valid=%0b expected 1 0", busy, out_valid); end
        got = 0; cyc = 0; busy_cnt = 0;
        while (got < 2 && cyc < 2000) begin
            if (busy) busy_cnt++;
            if (out_valid) begin
                if (got == 0) begin
                    n_cmp++;
                    if (busy_cnt != en + W) begin n_bad++; $display("FAIL both_latency: got %0d expected %0d", busy_cnt, en + W); end
                end
                e = exp_q.pop_front();
                n_cmp++;
                if (x_out !== e || out_data !== e[B-1:0]) begin
                    n_bad++;
                    $display("FAIL both_next_word: got x=%0d data=%0d expected x=%0d data=%0d", x_out, out_data, e, e[B-1:0]);
                end else $display("both next word %0d: x=%0d data=%0d", got, x_out, out_data);
                got++;
            end
            if (got < 2) tick();
            cyc++;
        end
        n_cmp++;
        if (got != 2) begin n_bad++; $display("FAIL both_timeout: words got %0d expected 2", got); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_sq();
        int cyc;
        logic [W-1:0] e;
        do_reset();
        out_ready = 1'b1;
        push_words(3, 4);
        offer_seed(W'(3));
        cyc = 0;
        while (!out_valid && cyc < 500) begin tick(); cyc++; end
        e = exp_q.pop_front();
        n_cmp++;
        if (x_out !== e) begin n_bad++; $display("FAIL midsq_first_word: got %0d expected %0d", x_out, e); end
        repeat (6) tick();
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL midsq_in_sq: busy=%0b valid=%0b expected 1 0", busy, out_valid); end
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (seed_ready !== 1'b1 || seed_err !== 1'b0) begin n_bad++; $display("FAIL midsq_reset_seed: ready=%0b err=%0b expected 1 0", seed_ready, seed_err); end
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin n_bad++; $display("FAIL midsq_reset_out: valid=%0b busy=%0b data=%0d expected 0 0 0", out_valid, busy, out_data); end
        if (x_out !== '0) begin n_bad++; $display("FAIL midsq_reset_x: got %0d expected 0", x_out); end
        else $display("mid-SQ reset: outputs at reset values");
        exp_q.delete();
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        test_stream(3, 4);
    endtask

    initial begin
        test_reset();
        test_stream(3, 4);
        do_reset();
        test_stream(5, 4);
        test_bad_seeds();
        test_hold();
        test_seed_during_out();
        test_reset_mid_sq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
